// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the core datapath to a multi-cycle data memory. Turns byte,
//   halfword and word loads/stores into word-aligned requests with byte
//   enables and lane-replicated write data. Runs a req/ack handshake,
//   stalls the core until the access completes, and returns the
//   sign/zero-extended load result.
//
// Ports
//   clk, reset           core clock, synchronous active-high reset
//   MemRead, MemWrite    current instruction is a load / store (both = store)
//   Funct3               access size and sign (Instr[14:12])
//   Addr, StoreData      byte address and rs2 value from the datapath
//   ReadData             extended load result (valid in the retire cycle)
//   Stall                freeze PC and suppress RegWrite this cycle
//   Fault                one-cycle pulse: misaligned, illegal Funct3, timeout
//   mem_req/we/addr/be/wdata   request to the data memory, held while busy
//   mem_rdata, mem_ack   read word and one-cycle completion strobe
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic          timeout_reg;
  logic [31:0]   rdata_reg;
  logic [1:0]    off_reg;   // Addr[1:0] of the access in flight
  logic [1:0]    size_reg;  // Funct3[1:0]: 00 byte, 01 half, 10 word
  logic          uns_reg;   // zero-extend the load
  logic          mem_req_reg, mem_we_reg;
  logic [31:0]   mem_addr_reg, mem_wdata_reg;
  logic [3:0]    mem_be_reg;

  // Request decode
  logic        access, is_store, legal, misaligned, start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  always_comb begin
    access     = MemRead | MemWrite;
    is_store   = MemWrite;
    legal      = 1'b0;
    be_next    = 4'b1111;
    wdata_next = StoreData;
    case (Funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;  // unsigned stores do not exist
      default:                legal = 1'b0;
    endcase
    misaligned = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                 ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
    case (Funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << Addr[1:0];
        wdata_next = {4{StoreData[7:0]}};
      end
      2'b01: begin
        be_next    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{StoreData[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = StoreData;
      end
    endcase
    start = (state_reg == IDLE) && access && legal && !misaligned;
  end

  // Lane extraction and extension of the returned word
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;

  always_comb begin
    lane_byte  = mem_rdata[7:0];
    case (off_reg)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      2'b00:   load_value = uns_reg ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_value = uns_reg ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_value = mem_rdata;
    endcase
    if (mem_we_reg) load_value = 32'h0;
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (mem_ack || cnt_reg == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;  // never re-trigger the same instruction
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Request / capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_be_reg    <= 4'h0;
      mem_wdata_reg <= 32'h0;
      rdata_reg     <= 32'h0;
      cnt_reg       <= '0;
      timeout_reg   <= 1'b0;
      off_reg       <= 2'b00;
      size_reg      <= 2'b00;
      uns_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          timeout_reg <= 1'b0;
          if (start) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= is_store;
            mem_addr_reg  <= {Addr[31:2], 2'b00};
            mem_be_reg    <= be_next;
            mem_wdata_reg <= wdata_next;
            off_reg       <= Addr[1:0];
            size_reg      <= Funct3[1:0];
            uns_reg       <= Funct3[2];
            cnt_reg       <= '0;
          end
        end
        BUSY: begin
          // An ack on the final count takes priority over the timeout.
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            rdata_reg   <= load_value;
          end else if (cnt_reg == CNT_LAST) begin
            mem_req_reg <= 1'b0;
            rdata_reg   <= 32'h0;
            timeout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE:    timeout_reg <= 1'b0;
        default: timeout_reg <= 1'b0;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Stall    = !reset && (start || state_reg == BUSY);
    Fault    = !reset &&
               (((state_reg == IDLE) && access && !(legal && !misaligned)) ||
                ((state_reg == DONE) && timeout_reg));
    ReadData = (state_reg == DONE) ? rdata_reg : 32'h0;
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, StoreData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  // Observations of the most recent access
  int          obs_stall, obs_req, obs_fault;
  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .StoreData(StoreData), .ReadData(ReadData),
    .Stall(Stall), .Fault(Fault), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Presents one instruction (starting just after a rising edge) and keeps it
  // until the cycle in which Stall is low, acting as a memory that acks in the
  // ack_at-th BUSY cycle (0 = never). Ends just after the following edge with
  // the access deasserted.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int ack_at, input logic [31:0] rdata);
    int  busy_n;
    bit  retired;
    busy_n = 0; retired = 0;
    obs_stall = 0; obs_req = 0; obs_fault = 0; obs_rd = 32'hx;
    obs_be = 4'hx; obs_addr = 32'hx; obs_wdata = 32'hx; obs_we = 1'bx;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; StoreData = sd;
    mem_rdata = rdata; mem_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (mem_req) begin
        busy_n++;
        mem_ack = (busy_n == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (Stall) obs_stall++;
      if (Fault) obs_fault++;
      if (mem_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
        end
      end
      if (!Stall) begin
        obs_rd  = ReadData;
        retired = 1;
        break;
      end
    end
    checks++;
    if (!retired) begin
      failures++;
      $display("FAIL access_retire: stall still high after 40 cycles, required retire");
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    Addr = 32'h100; StoreData = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b required 0", Stall); end
    checks++;
    if (Fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b required 0", Fault); end
    MemRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b required 0", mem_req); end
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b required 0", mem_we); end
    checks++;
    if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
    checks++;
    if (mem_be !== 4'h0) begin failures++; $display("FAIL reset_be: got %b required 0000", mem_be); end
    checks++;
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
    checks++;
    if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h required 0", ReadData); end
    $display("reset: req=%b be=%b stall=%b fault=%b rd=%h", mem_req, mem_be, Stall, Fault, ReadData);
    @(posedge clk); #1;
  endtask

  task automatic test_lw;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    $display("LW 0x100: be=%b addr=%h stall=%0d rd=%h fault=%0d", obs_be, obs_addr, obs_stall, obs_rd, obs_fault);
    checks++;
    if (obs_be !== 4'b1111) begin failures++; $display("FAIL lw_be: got %b required 1111", obs_be); end
    checks++;
    if (obs_addr !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h required 00000100", obs_addr); end
    checks++;
    if (obs_we !== 1'b0) begin failures++; $display("FAIL lw_we: got %b required 0", obs_we); end
    checks++;
    if (obs_stall != 4) begin failures++; $display("FAIL lw_stall: got %0d cycles required 4", obs_stall); end
    checks++;
    if (obs_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata: got %h required deadbeef", obs_rd); end
    checks++;
    if (obs_fault != 0) begin failures++; $display("FAIL lw_fault: got %0d pulses required 0", obs_fault); end
  endtask

  task automatic test_sub_word_loads;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF1234);
    $display("LB 0x103: be=%b rd=%h", obs_be, obs_rd);
    checks++;
    if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_be: got %b required 1000", obs_be); end
    checks++;
    if (obs_rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata: got %h required ffffff80", obs_rd); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
    $display("LBU 0x103: be=%b rd=%h", obs_be, obs_rd);
    checks++;
    if (obs_be !== 4'b1000) begin failures++; $display("FAIL lbu_be: got %b required 1000", obs_be); end
    checks++;
    if (obs_rd !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata: got %h required 00000080", obs_rd); end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80FF1234);
    $display("LH 0x102: be=%b rd=%h", obs_be, obs_rd);
    checks++;
    if (obs_be !== 4'b1100) begin failures++; $display("FAIL lh_be: got %b required 1100", obs_be); end
    checks++;
    if (obs_rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_rdata: got %h required ffff80ff", obs_rd); end
    run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1, 32'h80FF9234);
    $display("LHU 0x100: be=%b rd=%h", obs_be, obs_rd);
    checks++;
    if (obs_rd !== 32'h00009234) begin failures++; $display("FAIL lhu_rdata: got %h required 00009234", obs_rd); end
  endtask

  task automatic test_stores;
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h12345678);
    $display("SH 0x202: we=%b be=%b wdata=%h addr=%h stall=%0d rd=%h", obs_we, obs_be, obs_wdata, obs_addr, obs_stall, obs_rd);
    checks++;
    if (obs_we !== 1'b1) begin failures++; $display("FAIL sh_we: got %b required 1", obs_we); end
    checks++;
    if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be: got %b required 1100", obs_be); end
    checks++;
    if (obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata: got %h required abcdabcd", obs_wdata); end
    checks++;
    if (obs_addr !== 32'h200) begin failures++; $display("FAIL sh_addr: got %h required 00000200", obs_addr); end
    checks++;
    if (obs_stall != 2) begin failures++; $display("FAIL sh_stall: got %0d cycles required 2", obs_stall); end
    checks++;
    if (obs_rd !== 32'h0) begin failures++; $display("FAIL sh_rdata: got %h required 0", obs_rd); end
    // Both MemRead and MemWrite high behaves as a store
    run_access(1'b1, 1'b1, 3'b000, 32'h301, 32'h0000005A, 2, 32'hFFFFFFFF);
    $display("SB 0x301: we=%b be=%b wdata=%h addr=%h", obs_we, obs_be, obs_wdata, obs_addr);
    checks++;
    if (obs_we !== 1'b1) begin failures++; $display("FAIL sb_we: got %b required 1", obs_we); end
    checks++;
    if (obs_be !== 4'b0010) begin failures++; $display("FAIL sb_be: got %b required 0010", obs_be); end
    checks++;
    if (obs_wdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL sb_wdata: got %h required 5a5a5a5a", obs_wdata); end
  endtask

  task automatic test_faults;
    logic [2:0]  f3_v [3] = '{3'b010, 3'b001, 3'b100};
    logic [31:0] a_v  [3] = '{32'h101, 32'h203, 32'h100};
    logic        wr_v [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_access(~wr_v[i], wr_v[i], f3_v[i], a_v[i], 32'h11223344, 1, 32'hFFFFFFFF);
      $display("fault case %0d: f3=%b addr=%h req=%0d stall=%0d fault=%0d rd=%h", i, f3_v[i], a_v[i], obs_req, obs_stall, obs_fault, obs_rd);
      checks++;
      if (obs_req != 0) begin failures++; $display("FAIL fault%0d_req: got %0d req cycles required 0", i, obs_req); end
      checks++;
      if (obs_stall != 0) begin failures++; $display("FAIL fault%0d_stall: got %0d cycles required 0", i, obs_stall); end
      checks++;
      if (obs_fault != 1) begin failures++; $display("FAIL fault%0d_pulse: got %0d pulses required 1", i, obs_fault); end
      checks++;
      if (obs_rd !== 32'h0) begin failures++; $display("FAIL fault%0d_rdata: got %h required 0", i, obs_rd); end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || Fault !== 1'b0) begin
        failures++; $display("FAIL fault%0d_after: got req=%b fault=%b required 0/0", i, mem_req, Fault);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h55555555);
    $display("LW timeout: req=%0d stall=%0d fault=%0d rd=%h", obs_req, obs_stall, obs_fault, obs_rd);
    checks++;
    if (obs_req != 4) begin failures++; $display("FAIL to_req: got %0d req cycles required 4", obs_req); end
    checks++;
    if (obs_stall != 5) begin failures++; $display("FAIL to_stall: got %0d cycles required 5", obs_stall); end
    checks++;
    if (obs_fault != 1) begin failures++; $display("FAIL to_fault: got %0d pulses required 1", obs_fault); end
    checks++;
    if (obs_rd !== 32'h0) begin failures++; $display("FAIL to_rdata: got %h required 0", obs_rd); end
    @(negedge clk);
    checks++;
    if (Fault !== 1'b0 || mem_req !== 1'b0 || ReadData !== 32'h0) begin
      failures++; $display("FAIL to_idle: got fault=%b req=%b rd=%h required 0/0/0", Fault, mem_req, ReadData);
    end
    @(posedge clk); #1;
    // Ack on the final count wins
    run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 4, 32'h600DF00D);
    $display("LW ack on last count: req=%0d stall=%0d fault=%0d rd=%h", obs_req, obs_stall, obs_fault, obs_rd);
    checks++;
    if (obs_fault != 0) begin failures++; $display("FAIL lastack_fault: got %0d pulses required 0", obs_fault); end
    checks++;
    if (obs_rd !== 32'h600DF00D) begin failures++; $display("FAIL lastack_rdata: got %h required 600df00d", obs_rd); end
    checks++;
    if (obs_stall != 5) begin failures++; $display("FAIL lastack_stall: got %0d cycles required 5", obs_stall); end
  endtask

  task automatic test_reset_in_busy;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h500;
    mem_ack = 1'b0; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;          // BUSY cycle 1
    @(posedge clk); #1;          // BUSY cycle 2
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("FAIL rstbusy_stall_during: got %b required 0", Stall); end
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0; mem_ack = 1'b1;   // late ack
    @(negedge clk);
    $display("reset in BUSY: req=%b stall=%b fault=%b rd=%h", mem_req, Stall, Fault, ReadData);
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL rstbusy_req: got %b required 0", mem_req); end
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("FAIL rstbusy_stall: got %b required 0", Stall); end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (ReadData !== 32'h0 || mem_req !== 1'b0 || Fault !== 1'b0) begin
      failures++; $display("FAIL rstbusy_lateack: got rd=%h req=%b fault=%b required 0/0/0", ReadData, mem_req, Fault);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    run_access(1'b0, 1'b1, 3'b010, 32'h600, 32'h13579BDF, 1, 32'h0);
    $display("SW 0x600: we=%b be=%b wdata=%h", obs_we, obs_be, obs_wdata);
    checks++;
    if (obs_wdata !== 32'h13579BDF || obs_be !== 4'b1111) begin
      failures++; $display("FAIL b2b_sw: got wdata=%h be=%b required 13579bdf/1111", obs_wdata, obs_be);
    end
    run_access(1'b1, 1'b0, 3'b000, 32'h601, 32'h0, 1, 32'h00007F00);
    $display("LB 0x601: be=%b rd=%h", obs_be, obs_rd);
    checks++;
    if (obs_rd !== 32'h0000007F || obs_we !== 1'b0) begin
      failures++; $display("FAIL b2b_lb: got rd=%h we=%b required 0000007f/0", obs_rd, obs_we);
    end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sub_word_loads;
    test_stores;
    test_faults;
    test_timeout;
    test_reset_in_busy;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the core datapath, between its ALUResult/WriteData outputs and the external data memory; returns extended load data to the datapath ReadData input.
- Converts byte, halfword and word loads/stores into word-aligned requests with byte enables and lane-replicated write data.
- Runs a req/ack handshake with a multi-cycle memory and stalls the core (PC freeze, RegWrite gating) until the access completes, faults or times out.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without mem_ack before the access is aborted. Legal range 1..65535; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store
- Funct3  in  3  Instr[14:12]: access size/sign
- Addr  in  32  byte address (datapath ALUResult)
- StoreData  in  32  rs2 value (datapath WriteData)
- ReadData  out  32  extended load result to the datapath Result mux
- Stall  out  1  freeze PC and suppress RegWrite this cycle
- Fault  out  1  one-cycle pulse: misaligned, illegal Funct3 or timeout
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  {Addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; read-data register 0; timeout counter 0; Fault=0. Stall=0 while reset is high. A reset asserted in BUSY abandons the access; any later mem_ack is ignored.
- Access = MemRead|MemWrite. If both are high, treat as a store.
- Funct3 decode:
  - 000 = B (sign-extend)
  - 001 = H (sign-extend)
  - 010 = W
  - 100 = BU (zero-extend)
  - 101 = HU (zero-extend)
  - 100/101 with MemWrite = illegal; any other code = illegal.
- Byte enables: B = 0001<<Addr[1:0]; H = 0011<<(Addr[1]*2); W = 1111.
- Write data: B = {4{StoreData[7:0]}}; H = {2{StoreData[15:0]}}; W = StoreData.
- Misaligned: H with Addr[0]=1; W with Addr[1:0]!=0.
- FSM states IDLE, BUSY, DONE:
  - IDLE, no access: Stall=0, ReadData=0.
  - IDLE, access illegal or misaligned: no request issued, Stall=0, ReadData=0, Fault pulses for exactly this cycle (combinational, registered-free); stay IDLE. The core retires the instruction.
  - IDLE, access legal: Stall=1 combinationally. At the edge, latch mem_addr, mem_be, mem_wdata, mem_we and the size/sign, set mem_req=1, clear the counter, go to BUSY.
  - BUSY: Stall=1; mem_* outputs held stable. On mem_ack: mem_req<=0, capture the lane-extracted and extended mem_rdata (zero for stores), go to DONE. With no ack, the counter increments each cycle; when counter==TIMEOUT_CYCLES-1 and still no ack: mem_req<=0, read register<=0, Fault pulses the following cycle (in DONE), go to DONE. An ack on the final count wins over the timeout.
  - DONE: Stall=0; ReadData = captured value; the core retires and the PC advances at this edge. Next state is unconditionally IDLE, so the same instruction never re-triggers.
- Latency: a legal access with ack k cycles after mem_req rises gives Stall high for k+1 cycles; ReadData is valid in the DONE cycle.
- Load extraction: byte lane = Addr[1:0]; halfword = Addr[1] ? rdata[31:16] : rdata[15:0].
- mem_ack outside BUSY is ignored. mem_req never drops before ack or timeout.

Test Plan:
- LW, Addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after req -> mem_be=1111, mem_addr=0x100, Stall high 4 cycles, ReadData=0xDEADBEEF in DONE, Fault=0.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF1234 -> mem_be=1000; LB ReadData=0xFFFFFF80, LBU ReadData=0x00000080.
- SH, Addr=0x202, StoreData=0x0000ABCD, ack after 1 cycle -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200, Stall high 2 cycles.
- LW at 0x101 and SH at 0x203 -> mem_req stays 0, Stall=0, Fault pulses 1 cycle, ReadData=0. Also LBU-coded store (Funct3=100, MemWrite=1) -> same fault response.
- TIMEOUT_CYCLES=4, LW with no ack -> mem_req high exactly 4 cycles then 0, Fault pulses in DONE, ReadData=0, then IDLE. Ack arriving on the 4th BUSY cycle -> normal completion, no Fault.
- Reset asserted on the 2nd BUSY cycle, then a late mem_ack -> next cycle mem_req=0, Stall=0, state IDLE, late ack ignored.
